// File: rtl/bg_rom_arbiter.sv
// bg_rom_arbiter: shares one SDRAM tile-ROM read channel between two background
// layer fetchers. Each layer has one pending slot. The slots are granted
// round-robin, with one read outstanding at a time. Returned words are steered
// back to the layer that issued the read.
module bg_rom_arbiter #(
  parameter int AW      = 21,
  parameter int DW      = 32,
  parameter int TIMEOUT = 63
) (
  input  logic          CLK_32M,
  input  logic          RESET_N,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_rdy,
  output logic [DW-1:0] a_data,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_rdy,
  output logic [DW-1:0] b_data,
  output logic          sdr_req,
  output logic [AW-1:0] sdr_addr,
  input  logic          sdr_rdy,
  input  logic [DW-1:0] sdr_data,
  output logic          timeout_err,
  output logic [7:0]    ovf_cnt
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  // wcnt counts 0..TIMEOUT-1 while waiting. The abort fires on the cycle that
  // would make it reach TIMEOUT, so timeout_err lands TIMEOUT cycles after sdr_req.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [AW-1:0] slot_a_q, slot_a_d, slot_b_q, slot_b_d;
  logic          last_b_q, last_b_d;    // 1: the last grant went to layer B
  logic          owner_b_q, owner_b_d;  // 1: the outstanding read belongs to B
  logic [7:0]    wcnt_q, wcnt_d;
  logic          sdr_req_q, sdr_req_d;
  logic [AW-1:0] sdr_addr_q, sdr_addr_d;
  logic          a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic [DW-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic          tmo_q, tmo_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          gnt_a, gnt_b;
  logic [8:0]    ovf_sum;

  // Next-state: grant arbitration, wait/timeout tracking, slot and overflow update.
  always_comb begin
    state_d    = state_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    slot_a_d   = slot_a_q;
    slot_b_d   = slot_b_q;
    last_b_d   = last_b_q;
    owner_b_d  = owner_b_q;
    wcnt_d     = wcnt_q;
    sdr_req_d  = 1'b0;
    sdr_addr_d = sdr_addr_q;
    a_rdy_d    = 1'b0;
    b_rdy_d    = 1'b0;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    tmo_d      = 1'b0;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie, A wins unless A was the last layer granted.
        if (pend_a_q && (!pend_b_q || last_b_q)) gnt_a = 1'b1;
        else if (pend_b_q)                       gnt_b = 1'b1;
        if (gnt_a || gnt_b) begin
          sdr_req_d  = 1'b1;
          sdr_addr_d = gnt_a ? slot_a_q : slot_b_q;
          owner_b_d  = gnt_b;
          last_b_d   = gnt_b;
          wcnt_d     = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sdr_rdy) begin
          if (owner_b_q) begin
            b_rdy_d  = 1'b1;
            b_data_d = sdr_data;
          end else begin
            a_rdy_d  = 1'b1;
            a_data_d = sdr_data;
          end
          state_d = S_IDLE;
        end else if (wcnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new request on the grant edge refills the slot after the grant read it,
    // so setting the slot takes priority over clearing it.
    if (gnt_a) pend_a_d = 1'b0;
    if (gnt_b) pend_b_d = 1'b0;
    if (a_req) begin
      pend_a_d = 1'b1;
      slot_a_d = a_addr;
    end
    if (b_req) begin
      pend_b_d = 1'b1;
      slot_b_d = b_addr;
    end

    ovf_sum = {1'b0, ovf_q} + {8'd0, a_req & pend_a_q} + {8'd0, b_req & pend_b_q};
    ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  // State register. Reset is synchronous and abandons any outstanding read.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      slot_a_q   <= '0;
      slot_b_q   <= '0;
      last_b_q   <= 1'b1;
      owner_b_q  <= 1'b0;
      wcnt_q     <= '0;
      sdr_req_q  <= 1'b0;
      sdr_addr_q <= '0;
      a_rdy_q    <= 1'b0;
      b_rdy_q    <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      tmo_q      <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      slot_a_q   <= slot_a_d;
      slot_b_q   <= slot_b_d;
      last_b_q   <= last_b_d;
      owner_b_q  <= owner_b_d;
      wcnt_q     <= wcnt_d;
      sdr_req_q  <= sdr_req_d;
      sdr_addr_q <= sdr_addr_d;
      a_rdy_q    <= a_rdy_d;
      b_rdy_q    <= b_rdy_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sdr_req     = sdr_req_q;
  assign sdr_addr    = sdr_addr_q;
  assign a_rdy       = a_rdy_q;
  assign a_data      = a_data_q;
  assign b_rdy       = b_rdy_q;
  assign b_data      = b_data_q;
  assign timeout_err = tmo_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// tb_bg_rom_arbiter: scoreboard bench. The expected SDRAM addresses and the
// expected layer responses are queued when stimulus is driven, and they are
// popped by a negedge monitor.
module tb_bg_rom_arbiter;
  localparam int AW = 21, DW = 32, TMO = 63;

  logic          CLK_32M = 1'b0, RESET_N = 1'b0;
  logic          a_req = 1'b0, b_req = 1'b0, sdr_rdy = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] sdr_data = '0;
  logic          a_rdy, b_rdy, sdr_req, timeout_err;
  logic [DW-1:0] a_data, b_data;
  logic [AW-1:0] sdr_addr;
  logic [7:0]    ovf_cnt;

  bg_rom_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .CLK_32M(CLK_32M), .RESET_N(RESET_N),
    .a_req(a_req), .a_addr(a_addr), .a_rdy(a_rdy), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_rdy(b_rdy), .b_data(b_data),
    .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_rdy(sdr_rdy), .sdr_data(sdr_data),
    .timeout_err(timeout_err), .ovf_cnt(ovf_cnt)
  );

  always #5 CLK_32M = ~CLK_32M;

  typedef struct { logic lb; logic [AW-1:0] addr; } req_t;
  typedef struct { logic lb; logic [DW-1:0] data; } rsp_t;

  req_t exp_addr[$];
  logic inflight[$];
  rsp_t exp_rdy[$];
  int   n_chk = 0, n_err = 0;
  bit   sb_off = 1'b0;
  logic prev_req = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic do_reset;
    RESET_N = 1'b0; a_req = 1'b0; b_req = 1'b0; sdr_rdy = 1'b0;
    tick; tick;
    RESET_N = 1'b1;
    exp_addr.delete(); inflight.delete(); exp_rdy.delete();
  endtask

  task automatic expect_req(input logic lb, input logic [AW-1:0] ad);
    req_t e;
    e.lb = lb; e.addr = ad;
    exp_addr.push_back(e);
  endtask

  // Pulse requests for one cycle.
  task automatic req(input logic a, input logic b, input logic [AW-1:0] aa, input logic [AW-1:0] ba);
    a_req = a; b_req = b; a_addr = aa; b_addr = ba;
    tick;
    a_req = 1'b0; b_req = 1'b0;
  endtask

  // Returns at the negedge of the cycle where sdr_req is high. cyc is the number of negedges waited.
  task automatic wait_sdr(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_32M);
      cyc = i + 1;
      if (sdr_req === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("sdr_req_wait", 64'(sdr_req), 64'd1);
  endtask

  task automatic resp(input logic [DW-1:0] d);
    rsp_t r;
    sdr_rdy = 1'b1; sdr_data = d;
    if (inflight.size() > 0) begin
      r.lb = inflight.pop_front(); r.data = d;
      exp_rdy.push_back(r);
    end
    tick;
    sdr_rdy = 1'b0; sdr_data = '0;
  endtask

  task automatic serve(input int n, input int lat);
    bit ok; int c;
    for (int i = 0; i < n; i++) begin
      wait_sdr(ok, c);
      if (!ok) return;
      repeat (lat) tick;
      resp($urandom);
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && exp_rdy.size() > 0; i++) @(negedge CLK_32M);
    chk("drain_rdy", 64'(exp_rdy.size()), 64'd0);
    chk("drain_addr", 64'(exp_addr.size()), 64'd0);
  endtask

  // Monitor: checks the response scoreboard, SDRAM address order, single-outstanding rule.
  always @(negedge CLK_32M) begin
    rsp_t r;
    req_t q;
    if (RESET_N === 1'b1) begin
      if (a_rdy === 1'b1 || b_rdy === 1'b1) begin
        chk("rdy_excl", 64'(a_rdy & b_rdy), 64'd0);
        if (exp_rdy.size() == 0) chk("stray_rdy", 64'({a_rdy, b_rdy}), 64'd0);
        else begin
          r = exp_rdy.pop_front();
          chk("rdy_layer", 64'(b_rdy), 64'(r.lb));
          chk("rdy_data", 64'(r.lb ? b_data : a_data), 64'(r.data));
        end
      end
      if (!sb_off) begin
        if (sdr_req === 1'b1) begin
          chk("sdr_b2b", 64'(prev_req), 64'd0);
          if (exp_addr.size() == 0) chk("sdr_unexp", 64'(sdr_req), 64'd0);
          else begin
            q = exp_addr.pop_front();
            chk("sdr_addr", 64'(sdr_addr), 64'(q.addr));
            inflight.push_back(q.lb);
          end
        end
        if (timeout_err === 1'b1 && inflight.size() > 0) void'(inflight.pop_front());
      end
    end
    prev_req <= (sdr_req === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    do_reset;
    @(negedge CLK_32M);
    chk("rst_sdr_req", 64'(sdr_req), 64'd0);
    chk("rst_sdr_addr", 64'(sdr_addr), 64'd0);
    chk("rst_a_rdy", 64'(a_rdy), 64'd0);
    chk("rst_a_data", 64'(a_data), 64'd0);
    chk("rst_b_rdy", 64'(b_rdy), 64'd0);
    chk("rst_b_data", 64'(b_data), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);

    // single A read with exact latencies
    tick;                                   // cycle 0
    expect_req(1'b0, 21'h01234);
    a_req = 1'b1; a_addr = 21'h01234;
    tick; a_req = 1'b0;                     // cycle 1
    tick;                                   // cycle 2
    @(negedge CLK_32M);
    chk("t1_sdr_req", 64'(sdr_req), 64'd1);
    chk("t1_sdr_addr", 64'(sdr_addr), 64'h01234);
    repeat (3) tick;                        // cycle 5
    resp(32'hDEADBEEF);                     // now cycle 6
    @(negedge CLK_32M);
    chk("t1_a_rdy", 64'(a_rdy), 64'd1);
    chk("t1_a_data", 64'(a_data), 64'hDEADBEEF);
    chk("t1_b_rdy", 64'(b_rdy), 64'd0);
    tick;
    @(negedge CLK_32M);
    chk("t1_a_rdy_pulse", 64'(a_rdy), 64'd0);
    chk("t1_a_data_hold", 64'(a_data), 64'hDEADBEEF);

    // round-robin between the two layers
    do_reset;
    expect_req(1'b0, 21'h100); expect_req(1'b1, 21'h200);
    req(1'b1, 1'b1, 21'h100, 21'h200);
    serve(1, 3);
    wait_sdr(ok, k);
    chk("t2_regrant_lat", 64'(k), 64'd2);
    repeat (3) tick;
    resp($urandom);
    drain;
    expect_req(1'b0, 21'h300);
    req(1'b1, 1'b0, 21'h300, 21'h0);
    serve(1, 3); drain;
    expect_req(1'b1, 21'h201); expect_req(1'b0, 21'h101);
    req(1'b1, 1'b1, 21'h101, 21'h201);
    serve(2, 3); drain;
    chk("t2_ovf", 64'(ovf_cnt), 64'd0);

    // overwrite of a pending slot while the channel is busy
    do_reset;
    expect_req(1'b1, 21'h300);
    req(1'b0, 1'b1, 21'h0, 21'h300);
    wait_sdr(ok, k);                        // B outstanding
    tick; a_req = 1'b1; a_addr = 21'h10;
    tick; a_addr = 21'h20;
    tick; a_req = 1'b0;
    @(negedge CLK_32M);
    chk("t3_ovf1", 64'(ovf_cnt), 64'd1);
    expect_req(1'b0, 21'h20);
    tick; resp($urandom);
    serve(1, 3); drain;
    chk("t3_ovf1_keep", 64'(ovf_cnt), 64'd1);

    // saturation: a_req held for 300 cycles, 299 of them land on a pending slot
    do_reset;
    sb_off = 1'b1;
    a_req = 1'b1; a_addr = 21'h0;
    for (int i = 1; i < 300; i++) begin
      tick; a_addr = AW'(i);
      if (i == 100) begin
        @(negedge CLK_32M);
        chk("t3_ovf_mid", 64'(ovf_cnt), 64'd99);
      end
    end
    tick; a_req = 1'b0;
    @(negedge CLK_32M);
    chk("t3_ovf_sat", 64'(ovf_cnt), 64'd255);
    do_reset;
    sb_off = 1'b0;

    // timeout with the read withheld, then a stray sdr_rdy
    expect_req(1'b0, 21'h40);
    req(1'b1, 1'b0, 21'h40, 21'h0);
    wait_sdr(ok, k);
    k = 0; ok = 1'b0;
    while (k < 300) begin
      tick; k++;
      @(negedge CLK_32M);
      if (timeout_err === 1'b1) begin ok = 1'b1; break; end
    end
    chk("t4_tmo_seen", 64'(ok), 64'd1);
    chk("t4_tmo_lat", 64'(k), 64'(TMO));
    tick;
    @(negedge CLK_32M);
    chk("t4_tmo_pulse", 64'(timeout_err), 64'd0);
    tick; resp(32'h12345678);
    @(negedge CLK_32M);
    chk("t4_stray_a", 64'(a_rdy), 64'd0);
    chk("t4_stray_b", 64'(b_rdy), 64'd0);

    // reset while a read is outstanding
    do_reset;
    expect_req(1'b0, 21'h55);
    req(1'b1, 1'b0, 21'h55, 21'h0);
    serve(1, 3); drain;
    expect_req(1'b0, 21'h66);
    req(1'b1, 1'b0, 21'h66, 21'h0);
    wait_sdr(ok, k);
    tick; RESET_N = 1'b0;
    tick; RESET_N = 1'b1;
    exp_addr.delete(); inflight.delete(); exp_rdy.delete();
    @(negedge CLK_32M);
    chk("t5_sdr_req", 64'(sdr_req), 64'd0);
    chk("t5_sdr_addr", 64'(sdr_addr), 64'd0);
    chk("t5_a_rdy", 64'(a_rdy), 64'd0);
    chk("t5_a_data", 64'(a_data), 64'd0);
    chk("t5_b_rdy", 64'(b_rdy), 64'd0);
    chk("t5_b_data", 64'(b_data), 64'd0);
    chk("t5_tmo", 64'(timeout_err), 64'd0);
    chk("t5_ovf", 64'(ovf_cnt), 64'd0);
    tick; resp(32'hBAD0BAD0);
    @(negedge CLK_32M);
    chk("t5_stray_a", 64'(a_rdy), 64'd0);
    tick;
    expect_req(1'b0, 21'h77);
    req(1'b1, 1'b0, 21'h77, 21'h0);
    serve(1, 3); drain;

    // alternating traffic, one request every 8 cycles, 4-cycle SDRAM latency
    do_reset;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          expect_req(i[0], AW'(32'h1000 + i));
          if (i[0]) req(1'b0, 1'b1, 21'h0, AW'(32'h1000 + i));
          else      req(1'b1, 1'b0, AW'(32'h1000 + i), 21'h0);
          repeat (7) tick;
        end
      end
      serve(16, 4);
    join
    drain;
    chk("t6_ovf", 64'(ovf_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
